// File: rtl/ex_forward_ctrl_pkg.sv
// Shared pipeline definitions for the EX forwarding muxes and the forwarding control.
package ex_forward_ctrl_pkg;

  localparam int REG_AW = 5;

  // EX operand-mux select codes.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_ALU = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_IMM = 2'b11;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              reg_write;
    logic              mem_read;
  } shadow_t;

  // Loads in MEM are already resolved by the stall, so MEM only needs the write tag.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              reg_write;
  } wr_tag_t;

endpackage

// File: rtl/ex_forward_ctrl_src_cmp.sv
// Per-source hazard compare: EX-stage producer beats MEM-stage producer; r0 never matches.
module fwd_src_cmp
  import ex_forward_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_AW
) (
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic                  uses_i,
  input  logic                  ex_wr_i,
  input  logic [REG_ADDR_W-1:0] ex_dst_i,
  input  logic                  ex_load_i,
  input  logic                  mem_wr_i,
  input  logic [REG_ADDR_W-1:0] mem_dst_i,
  output logic [1:0]            code_o,
  output logic                  load_use_o
);

  logic src_live;
  logic hit_ex;
  logic hit_mem;

  assign src_live   = uses_i & (src_i != '0);
  assign hit_ex     = src_live & ex_wr_i  & (ex_dst_i  == src_i);
  assign hit_mem    = src_live & mem_wr_i & (mem_dst_i == src_i);
  assign code_o     = hit_ex ? FWD_ALU : (hit_mem ? FWD_WB : FWD_RF);
  assign load_use_o = hit_ex & ex_load_i;

endmodule

// File: rtl/ex_forward_ctrl.sv
// EX-stage forwarding select generation and load-use stall, tracking EX/MEM producers from ID.
module ex_forward_ctrl
  import ex_forward_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_AW,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_hold,
  input  logic                  in_flush,
  input  logic                  in_id_valid,
  input  logic [REG_ADDR_W-1:0] in_id_rs,
  input  logic [REG_ADDR_W-1:0] in_id_rt,
  input  logic [REG_ADDR_W-1:0] in_id_dst,
  input  logic                  in_id_uses_rs,
  input  logic                  in_id_uses_rt,
  input  logic                  in_id_alu_src,
  input  logic                  in_id_reg_write,
  input  logic                  in_id_mem_read,
  output logic [1:0]            out_forward_a,
  output logic [1:0]            out_forward_b,
  output logic [1:0]            out_forward_st,
  output logic                  out_stall,
  output logic [CNT_W-1:0]      out_stall_count
);

  shadow_t          ex_q, ex_d;
  wr_tag_t          mem_q;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [1:0]       fwd_st_q, fwd_st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] code_rs, code_rt;
  logic       lu_rs, lu_rt;
  logic       stall;
  logic       bubble;

  fwd_src_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_rs (
    .src_i      (in_id_rs),
    .uses_i     (in_id_uses_rs),
    .ex_wr_i    (ex_q.valid & ex_q.reg_write),
    .ex_dst_i   (ex_q.dst),
    .ex_load_i  (ex_q.mem_read),
    .mem_wr_i   (mem_q.valid & mem_q.reg_write),
    .mem_dst_i  (mem_q.dst),
    .code_o     (code_rs),
    .load_use_o (lu_rs)
  );

  fwd_src_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_rt (
    .src_i      (in_id_rt),
    .uses_i     (in_id_uses_rt),
    .ex_wr_i    (ex_q.valid & ex_q.reg_write),
    .ex_dst_i   (ex_q.dst),
    .ex_load_i  (ex_q.mem_read),
    .mem_wr_i   (mem_q.valid & mem_q.reg_write),
    .mem_dst_i  (mem_q.dst),
    .code_o     (code_rt),
    .load_use_o (lu_rt)
  );

  // Hold and flush both suppress the stall; the bubble covers every case where ID must not enter EX.
  assign stall  = in_id_valid & ~in_flush & ~in_hold & (lu_rs | lu_rt);
  assign bubble = ~in_id_valid | in_flush | stall;

  always_comb begin
    ex_d     = '0;
    fwd_a_d  = FWD_RF;
    fwd_b_d  = FWD_RF;
    fwd_st_d = FWD_RF;
    if (!bubble) begin
      ex_d.valid     = 1'b1;
      ex_d.dst       = in_id_dst;
      ex_d.reg_write = in_id_reg_write;
      ex_d.mem_read  = in_id_mem_read;
      fwd_a_d        = code_rs;
      fwd_b_d        = in_id_alu_src ? FWD_IMM : code_rt;
      fwd_st_d       = code_rt;
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q     <= '0;
      mem_q    <= '0;
      fwd_a_q  <= FWD_RF;
      fwd_b_q  <= FWD_RF;
      fwd_st_q <= FWD_RF;
      cnt_q    <= '0;
    end else if (!in_hold) begin
      ex_q            <= ex_d;
      mem_q.valid     <= ex_q.valid;
      mem_q.dst       <= ex_q.dst;
      mem_q.reg_write <= ex_q.reg_write;
      fwd_a_q         <= fwd_a_d;
      fwd_b_q         <= fwd_b_d;
      fwd_st_q        <= fwd_st_d;
      cnt_q           <= cnt_d;
    end
  end

  assign out_forward_a   = fwd_a_q;
  assign out_forward_b   = fwd_b_q;
  assign out_forward_st  = fwd_st_q;
  assign out_stall       = stall;
  assign out_stall_count = cnt_q;

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Bench for ex_forward_ctrl: pipeline-history reference model plus directed literal checks.
module tb_ex_forward_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, in_hold, in_flush, in_id_valid;
  logic [AW-1:0] in_id_rs, in_id_rt, in_id_dst;
  logic          in_id_uses_rs, in_id_uses_rt, in_id_alu_src, in_id_reg_write, in_id_mem_read;
  logic [1:0]    out_forward_a, out_forward_b, out_forward_st;
  logic          out_stall;
  logic [CW-1:0] out_stall_count;

  always #5 clk = ~clk;

  ex_forward_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_hold         (in_hold),
    .in_flush        (in_flush),
    .in_id_valid     (in_id_valid),
    .in_id_rs        (in_id_rs),
    .in_id_rt        (in_id_rt),
    .in_id_dst       (in_id_dst),
    .in_id_uses_rs   (in_id_uses_rs),
    .in_id_uses_rt   (in_id_uses_rt),
    .in_id_alu_src   (in_id_alu_src),
    .in_id_reg_write (in_id_reg_write),
    .in_id_mem_read  (in_id_mem_read),
    .out_forward_a   (out_forward_a),
    .out_forward_b   (out_forward_b),
    .out_forward_st  (out_forward_st),
    .out_stall       (out_stall),
    .out_stall_count (out_stall_count)
  );

  // Instructions that have entered EX: pipe[0] is in EX, pipe[1] in MEM (bubbles included).
  typedef struct {
    bit          v;
    bit [AW-1:0] d;
    bit          rw;
    bit          mr;
  } rec_t;

  rec_t     pipe[2];
  bit [1:0] m_fa, m_fb, m_fst;
  int       m_cnt;
  int       n_cmp = 0;
  int       n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit [1:0] m_code(input bit [AW-1:0] src, input bit uses);
    if (!uses || src == 0) return 2'b00;
    for (int age = 0; age < 2; age++)
      if (pipe[age].v && pipe[age].rw && pipe[age].d == src) return (age == 0) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    rec_t p;
    p = pipe[0];
    return in_id_valid && !in_flush && !in_hold && p.v && p.mr && p.rw && p.d != 0 &&
           ((in_id_uses_rs && in_id_rs == p.d) || (in_id_uses_rt && in_id_rt == p.d));
  endfunction

  task automatic model_clear();
    pipe[0] = '{default: 0};
    pipe[1] = '{default: 0};
    m_fa = 0; m_fb = 0; m_fst = 0; m_cnt = 0;
  endtask

  task automatic ins(input bit v, input bit [AW-1:0] rs, input bit [AW-1:0] rt, input bit [AW-1:0] dst,
                     input bit urs, input bit urt, input bit alu, input bit rw, input bit mr);
    reset = 0; in_hold = 0; in_flush = 0;
    in_id_valid = v; in_id_rs = rs; in_id_rt = rt; in_id_dst = dst;
    in_id_uses_rs = urs; in_id_uses_rt = urt; in_id_alu_src = alu;
    in_id_reg_write = rw; in_id_mem_read = mr;
  endtask

  // One clock: compare everything at the falling edge, then advance the model across the rising edge.
  task automatic tick();
    bit st, bub;
    @(negedge clk);
    st = m_stall();
    chk("stall",  32'(out_stall),       32'(st));
    chk("fwd_a",  32'(out_forward_a),   32'(m_fa));
    chk("fwd_b",  32'(out_forward_b),   32'(m_fb));
    chk("fwd_st", 32'(out_forward_st),  32'(m_fst));
    chk("count",  32'(out_stall_count), 32'(m_cnt));
    if (reset) begin
      model_clear();
    end else if (!in_hold) begin
      bub = !in_id_valid || in_flush || st;
      m_fa  = bub ? 2'b00 : m_code(in_id_rs, in_id_uses_rs);
      m_fst = bub ? 2'b00 : m_code(in_id_rt, in_id_uses_rt);
      m_fb  = bub ? 2'b00 : (in_id_alu_src ? 2'b11 : m_fst);
      pipe[1] = pipe[0];
      if (bub) pipe[0] = '{default: 0};
      else     pipe[0] = '{v: 1'b1, d: in_id_dst, rw: in_id_reg_write, mr: in_id_mem_read};
      if (st && m_cnt < (1 << CW) - 1) m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic i_add_r3();  ins(1, 1, 2, 3, 1, 1, 0, 1, 0); endtask
  task automatic i_sub_r4();  ins(1, 3, 5, 4, 1, 1, 0, 1, 0); endtask
  task automatic i_nop();     ins(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic i_lw_r8();   ins(1, 1, 0, 8, 1, 0, 1, 1, 1); endtask
  task automatic i_add_r9();  ins(1, 8, 2, 9, 1, 1, 0, 1, 0); endtask

  initial begin
    i_nop();
    reset = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_clear();
    i_nop();

    // Reset state
    chk("rst_fa",  32'(out_forward_a),   32'h0);
    chk("rst_fb",  32'(out_forward_b),   32'h0);
    chk("rst_fst", 32'(out_forward_st),  32'h0);
    chk("rst_st",  32'(out_stall),       32'h0);
    chk("rst_cnt", 32'(out_stall_count), 32'h0);

    // add r3 ; sub r4,r3,r5
    i_add_r3(); tick();
    i_sub_r4(); tick();
    chk("ex_fwd_a", 32'(out_forward_a), 32'h2);
    chk("ex_fwd_b", 32'(out_forward_b), 32'h0);

    // add r3 ; nop ; or r6,r7,r3
    i_add_r3(); tick();
    i_nop();    tick();
    ins(1, 7, 3, 6, 1, 1, 0, 1, 0); tick();
    chk("mem_fwd_b", 32'(out_forward_b), 32'h1);
    chk("mem_fwd_a", 32'(out_forward_a), 32'h0);

    // lw r8 ; add r9,r8,r2 -> one stall then MEM forward
    i_lw_r8();  tick();
    i_add_r9(); #1;
    chk("lu_stall", 32'(out_stall), 32'h1);
    tick();
    chk("lu_cnt", 32'(out_stall_count), 32'h1);
    chk("lu_bubble_a", 32'(out_forward_a), 32'h0);
    #1;
    chk("lu_stall_clear", 32'(out_stall), 32'h0);
    tick();
    chk("lu_fwd_a", 32'(out_forward_a), 32'h1);

    // r0 producer never forwards
    ins(1, 0, 0, 0, 1, 0, 1, 1, 0); tick();
    ins(1, 0, 0, 4, 1, 1, 0, 1, 0); #1;
    chk("r0_stall", 32'(out_stall), 32'h0);
    tick();
    chk("r0_fa", 32'(out_forward_a), 32'h0);
    chk("r0_fb", 32'(out_forward_b), 32'h0);

    // add r3 ; sw r3,4(r1)
    i_add_r3(); tick();
    ins(1, 1, 3, 0, 1, 1, 1, 0, 0); tick();
    chk("sw_fb",  32'(out_forward_b),  32'h3);
    chk("sw_fst", 32'(out_forward_st), 32'h2);

    // load-use with flush: no stall, bubble, count unchanged
    i_lw_r8();  tick();
    i_add_r9(); in_flush = 1; #1;
    chk("fl_stall", 32'(out_stall), 32'h0);
    tick();
    chk("fl_fa",  32'(out_forward_a),   32'h0);
    chk("fl_cnt", 32'(out_stall_count), 32'h1);
    i_nop(); tick();

    // hold for 3 cycles freezes everything
    i_add_r3(); tick();
    i_sub_r4(); tick();
    for (int k = 0; k < 3; k++) begin
      i_lw_r8(); in_hold = 1; tick();
      chk("hold_fa",  32'(out_forward_a),   32'h2);
      chk("hold_fb",  32'(out_forward_b),   32'h0);
      chk("hold_cnt", 32'(out_stall_count), 32'h1);
    end

    // reset during a stall
    i_lw_r8();  tick();
    i_add_r9(); #1;
    chk("rs_stall_pre", 32'(out_stall), 32'h1);
    reset = 1; tick();
    i_add_r9(); #1;
    chk("rs_fa",    32'(out_forward_a),   32'h0);
    chk("rs_cnt",   32'(out_stall_count), 32'h0);
    chk("rs_stall", 32'(out_stall),       32'h0);

    // drive the counter into saturation
    for (int k = 0; k < 20; k++) begin
      i_lw_r8();  tick();
      i_add_r9(); tick();
      tick();
    end
    i_nop(); tick();
    chk("sat_cnt", 32'(out_stall_count), 32'hF);

    // randomized traffic on a small register set to keep hazards dense
    for (int n = 0; n < 3000; n++) begin
      ins(bit'($urandom_range(0, 99) < 85),
          AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
          bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) == 0));
      in_hold  = ($urandom_range(0, 99) < 10);
      in_flush = ($urandom_range(0, 99) < 10);
      reset    = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
